ov7725_cfg_ctrl: RTL and testbench

- Power-up configuration sequencer for the OV7725 camera.
- Walks a fixed register table and drives the sccb transaction engine one register at a time:
  - waits for sensor power-up;
  - issues a soft reset and waits again;
  - writes every entry, and optionally reads each one back and compares it.
- Sits between top-level reset and the sccb instance, and gates the downstream capture logic via cfg_done.

---
 rtl/ov7725_pkg.sv | 27 ++
 rtl/ov7725_cfg_rom.sv | 46 ++++
 rtl/ov7725_cfg_ctrl.sv | 156 +++++++++++++++
 tb/tb_ov7725_cfg_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ov7725_pkg.sv
// Shared definitions for the OV7725 power-up configuration sequencer:
// FSM state encoding, sensor register addresses and the soft-reset word.
package ov7725_pkg;

  typedef enum logic [3:0] {
    S_PWR_WAIT = 4'd0,
    S_WR_START = 4'd1,
    S_WR_BUSY  = 4'd2,
    S_RST_WAIT = 4'd3,
    S_RD_START = 4'd4,
    S_RD_BUSY  = 4'd5,
    S_CHECK    = 4'd6,
    S_NEXT     = 4'd7,
    S_DONE     = 4'd8
  } cfg_state_t;

  localparam logic [7:0] REG_COM7   = 8'h12;
  localparam logic [7:0] REG_HSTART = 8'h17;
  localparam logic [7:0] REG_HSIZE  = 8'h18;
  localparam logic [7:0] REG_VSTRT  = 8'h19;
  localparam logic [7:0] REG_VSIZE  = 8'h1A;
  localparam logic [7:0] REG_DSP    = 8'h3D;

  // COM7 bit 7 resets every sensor register; the bit clears itself
  localparam logic [15:0] SOFT_RST_WORD = {REG_COM7, 8'h80};

endpackage

// File: rtl/ov7725_cfg_rom.sv
// Register table for the OV7725 QVGA/RGB565 setup: {address, data} per index.
// Entry 0 is always the soft reset; indices at or beyond REG_NUM read as zero.
module ov7725_cfg_rom
  import ov7725_pkg::*;
#(
  parameter logic [7:0] REG_NUM = 8'd70
) (
  input  logic [7:0]  idx,
  output logic [15:0] cfg_word
);

  logic [15:0] rom_word;

  always_comb begin
    rom_word = 16'h0000;
    case (idx)
      8'd0:  rom_word = SOFT_RST_WORD;
      8'd1:  rom_word = 16'h3D03;  8'd2:  rom_word = 16'h1722;  8'd3:  rom_word = 16'h18A4;
      8'd4:  rom_word = 16'h1907;  8'd5:  rom_word = 16'h1AF0;  8'd6:  rom_word = 16'h3200;
      8'd7:  rom_word = 16'h29A0;  8'd8:  rom_word = 16'h2CF0;  8'd9:  rom_word = 16'h2A00;
      8'd10: rom_word = 16'h1100;  8'd11: rom_word = 16'h1246;  8'd12: rom_word = 16'h0C10;
      8'd13: rom_word = 16'h4200;  8'd14: rom_word = 16'h4D09;  8'd15: rom_word = 16'h63E0;
      8'd16: rom_word = 16'h6400;  8'd17: rom_word = 16'h6520;  8'd18: rom_word = 16'h6600;
      8'd19: rom_word = 16'h6700;  8'd20: rom_word = 16'h13F0;  8'd21: rom_word = 16'h0D41;
      8'd22: rom_word = 16'h0F01;  8'd23: rom_word = 16'h1430;  8'd24: rom_word = 16'h2275;
      8'd25: rom_word = 16'h233F;  8'd26: rom_word = 16'h24A0;  8'd27: rom_word = 16'h2580;
      8'd28: rom_word = 16'h2603;  8'd29: rom_word = 16'h2B00;  8'd30: rom_word = 16'h6BAA;
      8'd31: rom_word = 16'h1368;  8'd32: rom_word = 16'h9000;  8'd33: rom_word = 16'h910A;
      8'd34: rom_word = 16'h9201;  8'd35: rom_word = 16'h9301;  8'd36: rom_word = 16'h94B0;
      8'd37: rom_word = 16'h959C;  8'd38: rom_word = 16'h9613;  8'd39: rom_word = 16'h9716;
      8'd40: rom_word = 16'h987B;  8'd41: rom_word = 16'h9991;  8'd42: rom_word = 16'h9A1E;
      8'd43: rom_word = 16'h9B08;  8'd44: rom_word = 16'h9C20;  8'd45: rom_word = 16'h9E81;
      8'd46: rom_word = 16'hA606;  8'd47: rom_word = 16'h7E0C;  8'd48: rom_word = 16'h7F16;
      8'd49: rom_word = 16'h802A;  8'd50: rom_word = 16'h814E;  8'd51: rom_word = 16'h8261;
      8'd52: rom_word = 16'h836F;  8'd53: rom_word = 16'h847B;  8'd54: rom_word = 16'h8586;
      8'd55: rom_word = 16'h868E;  8'd56: rom_word = 16'h8797;  8'd57: rom_word = 16'h88A4;
      8'd58: rom_word = 16'h89AF;  8'd59: rom_word = 16'h8AC5;  8'd60: rom_word = 16'h8BD7;
      8'd61: rom_word = 16'h8CE8;  8'd62: rom_word = 16'h8D20;  8'd63: rom_word = 16'h0E65;
      8'd64: rom_word = 16'h0900;  8'd65: rom_word = 16'hA9F8;  8'd66: rom_word = 16'hAAFF;
      8'd67: rom_word = 16'hABFF;  8'd68: rom_word = 16'h9F00;  8'd69: rom_word = 16'hA000;
      default: rom_word = 16'h0000;
    endcase
    cfg_word = (idx < REG_NUM) ? rom_word : 16'h0000;
  end

endmodule

// File: rtl/ov7725_cfg_ctrl.sv
// OV7725 power-up sequencer: power-up wait, soft reset, then writes every
// table entry through the sccb engine with optional read-back and retry.
module ov7725_cfg_ctrl
  import ov7725_pkg::*;
#(
  parameter logic [7:0] REG_NUM      = 8'd70,
  parameter logic [9:0] CNT_WAIT_MAX = 10'd1000,
  parameter logic [9:0] CNT_RST_MAX  = 10'd1000,
  parameter logic       VERIFY_EN    = 1'b1,
  parameter logic [1:0] MAX_RETRY    = 2'd3
) (
  input  logic        i2c_clk,
  input  logic        sys_rst_n,
  input  logic        cfg_restart,
  input  logic        i2c_end,
  input  logic [7:0]  rd_data,
  output logic        i2c_start,
  output logic        wr_en,
  output logic        rd_en,
  output logic        addr_num,
  output logic [15:0] byte_addr,
  output logic [7:0]  wr_data,
  output logic [7:0]  cfg_idx,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic [7:0]  fail_cnt
);

  cfg_state_t  state, state_nxt;
  logic [9:0]  cnt_wait, cnt_nxt;
  logic [7:0]  idx_nxt, rd_cap, cap_nxt, fail_nxt;
  logic [1:0]  retry_cnt, retry_nxt, retry_inc;
  logic        err_nxt;
  logic [15:0] cfg_word;

  ov7725_cfg_rom #(.REG_NUM(REG_NUM)) u_rom (
    .idx      (cfg_idx),
    .cfg_word (cfg_word)
  );

  assign addr_num  = 1'b0;
  assign byte_addr = {8'h00, cfg_word[15:8]};
  assign wr_data   = cfg_word[7:0];

  always_ff @(posedge i2c_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= S_PWR_WAIT;
      cnt_wait  <= '0;
      cfg_idx   <= '0;
      retry_cnt <= '0;
      rd_cap    <= '0;
      cfg_err   <= 1'b0;
      fail_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      cnt_wait  <= cnt_nxt;
      cfg_idx   <= idx_nxt;
      retry_cnt <= retry_nxt;
      rd_cap    <= cap_nxt;
      cfg_err   <= err_nxt;
      fail_cnt  <= fail_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_wait;
    idx_nxt   = cfg_idx;
    retry_nxt = retry_cnt;
    retry_inc = retry_cnt + 2'd1;
    cap_nxt   = rd_cap;
    err_nxt   = cfg_err;
    fail_nxt  = fail_cnt;
    i2c_start = 1'b0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    cfg_done  = 1'b0;
    case (state)
      S_PWR_WAIT: begin
        if (cnt_wait == CNT_WAIT_MAX - 10'd1) begin
          cnt_nxt   = '0;
          state_nxt = S_WR_START;
        end else begin
          cnt_nxt = cnt_wait + 10'd1;
        end
      end
      S_WR_START: begin
        i2c_start = 1'b1;
        wr_en     = 1'b1;
        state_nxt = S_WR_BUSY;
      end
      S_WR_BUSY: begin
        wr_en = 1'b1;
        if (i2c_end) begin
          if (cfg_idx == 8'd0)  state_nxt = S_RST_WAIT;
          else if (VERIFY_EN)   state_nxt = S_RD_START;
          else                  state_nxt = S_NEXT;
        end
      end
      // the soft-reset entry clears itself, so it is waited out, not verified
      S_RST_WAIT: begin
        if (cnt_wait == CNT_RST_MAX - 10'd1) begin
          cnt_nxt   = '0;
          state_nxt = S_NEXT;
        end else begin
          cnt_nxt = cnt_wait + 10'd1;
        end
      end
      S_RD_START: begin
        i2c_start = 1'b1;
        rd_en     = 1'b1;
        state_nxt = S_RD_BUSY;
      end
      S_RD_BUSY: begin
        rd_en = 1'b1;
        if (i2c_end) begin
          cap_nxt   = rd_data;
          state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (rd_cap == wr_data) begin
          retry_nxt = '0;
          state_nxt = S_NEXT;
        end else if (retry_inc == MAX_RETRY) begin
          retry_nxt = '0;
          err_nxt   = 1'b1;
          fail_nxt  = (fail_cnt == 8'hFF) ? fail_cnt : fail_cnt + 8'd1;
          state_nxt = S_NEXT;
        end else begin
          retry_nxt = retry_inc;
          state_nxt = S_WR_START;
        end
      end
      S_NEXT: begin
        if (cfg_idx == REG_NUM - 8'd1) begin
          state_nxt = S_DONE;
        end else begin
          idx_nxt   = cfg_idx + 8'd1;
          state_nxt = S_WR_START;
        end
      end
      S_DONE: begin
        cfg_done = 1'b1;
        if (cfg_restart) begin
          idx_nxt   = '0;
          err_nxt   = 1'b0;
          fail_nxt  = '0;
          state_nxt = S_PWR_WAIT;
        end
      end
      default: state_nxt = S_PWR_WAIT;
    endcase
  end

endmodule

// File: tb/tb_ov7725_cfg_ctrl.sv
// Directed bench: two sequencers (verify on / off) driven by a behavioural
// SCCB slave that stores writes and echoes them on reads.
module tb_ov7725_cfg_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic bad17;
  logic [1:0] restart, start, wr_en, rd_en, i2c_end, addr_num, done, err;
  logic [1:0][15:0] byte_addr;
  logic [1:0][7:0]  wr_data, rd_data, idx, fail;

  always #5 clk = ~clk;

  ov7725_cfg_ctrl #(.REG_NUM(8'd4), .CNT_WAIT_MAX(10'd10), .CNT_RST_MAX(10'd10),
                    .VERIFY_EN(1'b1), .MAX_RETRY(2'd3)) dut (
    .i2c_clk(clk), .sys_rst_n(rst_n), .cfg_restart(restart[0]), .i2c_end(i2c_end[0]),
    .rd_data(rd_data[0]), .i2c_start(start[0]), .wr_en(wr_en[0]), .rd_en(rd_en[0]),
    .addr_num(addr_num[0]), .byte_addr(byte_addr[0]), .wr_data(wr_data[0]),
    .cfg_idx(idx[0]), .cfg_done(done[0]), .cfg_err(err[0]), .fail_cnt(fail[0]));

  ov7725_cfg_ctrl #(.REG_NUM(8'd4), .CNT_WAIT_MAX(10'd10), .CNT_RST_MAX(10'd10),
                    .VERIFY_EN(1'b0), .MAX_RETRY(2'd3)) dut_nv (
    .i2c_clk(clk), .sys_rst_n(rst_n), .cfg_restart(restart[1]), .i2c_end(i2c_end[1]),
    .rd_data(rd_data[1]), .i2c_start(start[1]), .wr_en(wr_en[1]), .rd_en(rd_en[1]),
    .addr_num(addr_num[1]), .byte_addr(byte_addr[1]), .wr_data(wr_data[1]),
    .cfg_idx(idx[1]), .cfg_done(done[1]), .cfg_err(err[1]), .fail_cnt(fail[1]));

  // slave: fixed 5-cycle transaction, i2c_end and rd_data valid together
  logic [1:0]      busy, is_rd;
  logic [1:0][2:0] cnt;
  logic [1:0][7:0] a_l, d_l;
  logic [7:0]      mem [2][256];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0; is_rd <= '0; cnt <= '0; a_l <= '0; d_l <= '0;
      i2c_end <= '0; rd_data <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        i2c_end[i] <= 1'b0;
        if (start[i]) begin
          busy[i] <= 1'b1; cnt[i] <= 3'd4; is_rd[i] <= rd_en[i];
          a_l[i] <= byte_addr[i][7:0]; d_l[i] <= wr_data[i];
        end else if (busy[i]) begin
          if (cnt[i] == 3'd0) begin
            busy[i] <= 1'b0;
            i2c_end[i] <= 1'b1;
            if (is_rd[i])
              rd_data[i] <= (i == 0 && bad17 && a_l[i] == 8'h17) ? 8'h00 : mem[i][a_l[i]];
            else
              mem[i][a_l[i]] <= d_l[i];
          end else begin
            cnt[i] <= cnt[i] - 3'd1;
          end
        end
      end
    end
  end

  logic [8:0] log0[$], log1[$], exp_q[$];
  logic rd1_seen;

  always @(posedge clk) begin
    if (rst_n) begin
      if (start[0]) log0.push_back({rd_en[0], byte_addr[0][7:0]});
      if (start[1]) log1.push_back({rd_en[1], byte_addr[1][7:0]});
      if (rd_en[1]) rd1_seen = 1'b1;
    end
  end

  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_log(input string tag, input int inst);
    int n;
    n = (inst == 0) ? log0.size() : log1.size();
    chk({tag, "_len"}, n, exp_q.size());
    for (int i = 0; i < n && i < exp_q.size(); i++)
      chk($sformatf("%s_%0d", tag, i), (inst == 0) ? log0[i] : log1[i], exp_q[i]);
  endtask

  task automatic cycles_to_start(output int n);
    n = 0;
    while (!start[0] && n < 200) begin
      @(posedge clk); n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input logic [1:0] mask);
    int n = 0;
    while (((done & mask) != mask) && n < 3000) begin
      @(negedge clk); n++;
    end
  endtask

  task automatic restart0;
    @(negedge clk);
    restart[0] = 1'b1;
    log0.delete();
    @(negedge clk);
    restart[0] = 1'b0;
  endtask

  int n, g;

  initial begin
    rst_n = 1'b0; restart = '0; bad17 = 1'b0; rd1_seen = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_start", start[0], 0);
    chk("rst_wr_en", wr_en[0], 0);
    chk("rst_rd_en", rd_en[0], 0);
    chk("rst_idx", idx[0], 0);
    chk("rst_done_err", {done[0], err[0]}, 0);
    chk("rst_fail", fail[0], 0);
    chk("addr_num", addr_num, 0);

    // power-up wait, then soft-reset write
    rst_n = 1'b1;
    cycles_to_start(n);
    chk("pwr_wait_cycles", n, 10);
    chk("w0_wr_en", {wr_en[0], rd_en[0]}, 2'b10);
    chk("w0_byte_addr", byte_addr[0], 16'h0012);
    chk("w0_wr_data", wr_data[0], 8'h80);
    @(negedge clk);
    chk("start_one_cycle", {start[0], wr_en[0]}, 2'b01);
    restart[0] = 1'b1;        // ignored outside S_DONE
    @(negedge clk);
    restart[0] = 1'b0;
    n = 0;
    while (!i2c_end[0] && n < 50) begin @(negedge clk); n++; end
    cycles_to_start(g);
    chk("rst_gap_ge10", (g >= 10), 1);
    chk("w1_byte_addr", byte_addr[0], 16'h003D);

    wait_done(2'b11);
    exp_q = '{9'h012, 9'h03D, 9'h13D, 9'h017, 9'h117, 9'h018, 9'h118};
    chk_log("echo", 0);
    chk("echo_done", done[0], 1);
    chk("echo_err", err[0], 0);
    chk("echo_fail", fail[0], 0);
    exp_q = '{9'h012, 9'h03D, 9'h017, 9'h018};
    chk_log("nv", 1);
    chk("nv_rd_seen", rd1_seen, 0);
    chk("nv_done", done[1], 1);

    // restart from S_DONE repeats the same sequence
    restart0();
    chk("restart_done_clr", done[0], 0);
    chk("restart_idx", idx[0], 0);
    wait_done(2'b01);
    exp_q = '{9'h012, 9'h03D, 9'h13D, 9'h017, 9'h117, 9'h018, 9'h118};
    chk_log("repeat", 0);
    chk("repeat_flags", {done[0], err[0]}, 2'b10);

    // register 0x17 never reads back correctly
    bad17 = 1'b1;
    restart0();
    wait_done(2'b01);
    exp_q = '{9'h012, 9'h03D, 9'h13D, 9'h017, 9'h117, 9'h017, 9'h117,
              9'h017, 9'h117, 9'h018, 9'h118};
    chk_log("bad17", 0);
    chk("bad17_done", done[0], 1);
    chk("bad17_err", err[0], 1);
    chk("bad17_fail", fail[0], 1);

    bad17 = 1'b0;
    restart0();
    chk("restart_err_clr", err[0], 0);
    chk("restart_fail_clr", fail[0], 0);

    // reset in the middle of the 0x3D read-back
    n = 0;
    while (!(rd_en[0] && byte_addr[0][7:0] == 8'h3D) && n < 500) begin @(negedge clk); n++; end
    chk("r3d_reached", rd_en[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {start[0], wr_en[0], rd_en[0], done[0], err[0]}, 0);
    chk("mid_rst_idx", idx[0], 0);
    chk("mid_rst_fail", fail[0], 0);
    @(negedge clk);
    log0.delete();
    rst_n = 1'b1;
    cycles_to_start(n);
    chk("post_rst_wait", n, 10);
    chk("post_rst_idx", idx[0], 0);
    chk("post_rst_addr", byte_addr[0], 16'h0012);
    wait_done(2'b01);
    exp_q = '{9'h012, 9'h03D, 9'h13D, 9'h017, 9'h117, 9'h018, 9'h118};
    chk_log("post_rst", 0);
    chk("post_rst_flags", {done[0], err[0]}, 2'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
